// File: rtl/fetch_pkg.sv
// fetch_pkg: shared types and constants for the instruction-fetch stage
package fetch_pkg;
  localparam int XLEN = 16;
  localparam int INSN_BYTES = 2;
  localparam logic [XLEN-1:0] NOP_INSN = 16'h0000;
  typedef enum logic [1:0] {IDLE, REQ, WAIT, DROP} state_t;
endpackage

// File: rtl/fetch_buffer.sv
// fetch_buffer: flushable FIFO of {pc, ir} pairs feeding the IF/ID register
module fetch_buffer import fetch_pkg::*; #(
  parameter int DEPTH = 2,
  localparam int AW = $clog2(DEPTH),
  localparam int CW = AW + 1
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            flush,
  input  logic            push,
  input  logic            pop,
  input  logic [XLEN-1:0] push_pc,
  input  logic [XLEN-1:0] push_ir,
  output logic [CW-1:0]   count,
  output logic            valid,
  output logic [XLEN-1:0] head_pc,
  output logic [XLEN-1:0] head_ir
);
  logic [XLEN-1:0] pcs [DEPTH];
  logic [XLEN-1:0] irs [DEPTH];
  logic [AW-1:0] rd, wr;
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      rd <= '0;
      wr <= '0;
      count <= '0;
    end else if (flush) begin
      rd <= '0;
      wr <= '0;
      count <= '0;
    end else begin
      if (push) wr <= wr + 1'b1;
      if (pop) rd <= rd + 1'b1;
      count <= count + CW'(push) - CW'(pop);
    end
  always_ff @(posedge clk)
    if (push && !flush) begin
      pcs[wr] <= push_pc;
      irs[wr] <= push_ir;
    end
  // empty head presents a NOP bubble rather than stale storage
  always_comb begin
    valid = count != '0;
    head_pc = valid ? pcs[rd] : '0;
    head_ir = valid ? irs[rd] : NOP_INSN;
  end
endmodule

// File: rtl/fetch_stage.sv
// fetch_stage: fetch PC and single-outstanding imem FSM producing the {pc, pc+2, ir} head
module fetch_stage import fetch_pkg::*; #(
  parameter logic [XLEN-1:0] RESET_PC = 16'h0000,
  parameter int BUF_DEPTH = 2
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            jump,
  input  logic [XLEN-1:0] new_pc,
  input  logic            stall,
  output logic            imem_req,
  output logic [XLEN-1:0] imem_addr,
  input  logic            imem_ready,
  input  logic            imem_rvalid,
  input  logic [XLEN-1:0] imem_rdata,
  output logic            valid_out,
  output logic [XLEN-1:0] pc_out,
  output logic [XLEN-1:0] pcp2_out,
  output logic [XLEN-1:0] ir_out
);
  localparam int CW = $clog2(BUF_DEPTH) + 1;
  localparam logic [CW-1:0] FULL = CW'(BUF_DEPTH);
  localparam logic [XLEN-1:0] STEP = XLEN'(INSN_BYTES);
  state_t state, next;
  logic [XLEN-1:0] fetch_pc, req_pc, target;
  logic [CW-1:0] count, post;
  logic accept, push, pop;
  fetch_buffer #(.DEPTH(BUF_DEPTH)) buffer (
    .clk(clk), .reset(reset), .flush(jump), .push(push), .pop(pop),
    .push_pc(req_pc), .push_ir(imem_rdata), .count(count),
    .valid(valid_out), .head_pc(pc_out), .head_ir(ir_out)
  );
  // a redirect leaves IDLE/DROP transitions alone so DROP still retires its response
  always_comb begin
    target = {new_pc[XLEN-1:1], 1'b0};
    accept = state == REQ && imem_ready;
    push = state == WAIT && imem_rvalid && !jump;
    pop = valid_out && !stall;
    post = count + CW'(push) - CW'(pop);
    imem_req = state == REQ;
    imem_addr = fetch_pc;
    pcp2_out = valid_out ? pc_out + STEP : '0;
    next = state;
    case (state)
      IDLE: next = count < FULL ? REQ : IDLE;
      REQ:  next = imem_ready ? (jump ? DROP : WAIT) : REQ;
      WAIT: next = imem_rvalid ? (jump || post < FULL ? REQ : IDLE) : (jump ? DROP : WAIT);
      DROP: next = imem_rvalid ? (count < FULL ? REQ : IDLE) : DROP;
    endcase
  end
  always_ff @(posedge clk or posedge reset)
    if (reset) state <= IDLE;
    else state <= next;
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      fetch_pc <= RESET_PC;
      req_pc <= RESET_PC;
    end else begin
      fetch_pc <= jump ? target : accept ? fetch_pc + STEP : fetch_pc;
      if (accept) req_pc <= fetch_pc;
    end
endmodule

// File: tb/tb_fetch_stage.sv
// tb_fetch_stage: directed checks of fetch_stage against hand-computed vectors
module tb_fetch_stage;
  logic clk = 0, reset = 0, jump = 0, stall = 0;
  logic [15:0] new_pc = 0;
  logic imem_req, imem_ready, imem_rvalid, valid_out;
  logic [15:0] imem_addr, imem_rdata, pc_out, pcp2_out, ir_out;
  logic auto = 1, man_ready = 0, man_rvalid = 0;
  logic [15:0] man_rdata = 0;
  logic pend0, pend1;
  logic [15:0] data0, data1;
  logic req1, valid1, ready1 = 1, jump1 = 0, stall1 = 0;
  logic [15:0] addr1, pc1, pcp21, ir1, npc1 = 0;
  int checks = 0, errors = 0;

  always #5 clk = ~clk;

  fetch_stage dut (
    .clk(clk), .reset(reset), .jump(jump), .new_pc(new_pc), .stall(stall),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_ready(imem_ready),
    .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata), .valid_out(valid_out),
    .pc_out(pc_out), .pcp2_out(pcp2_out), .ir_out(ir_out)
  );

  fetch_stage #(.RESET_PC(16'hFFFC)) dut1 (
    .clk(clk), .reset(reset), .jump(jump1), .new_pc(npc1), .stall(stall1),
    .imem_req(req1), .imem_addr(addr1), .imem_ready(ready1),
    .imem_rvalid(pend1), .imem_rdata(data1), .valid_out(valid1),
    .pc_out(pc1), .pcp2_out(pcp21), .ir_out(ir1)
  );

  function automatic logic [15:0] word(input logic [15:0] a);
    return a == 16'h0000 ? 16'h1111 : a == 16'h0002 ? 16'h2222 : a ^ 16'hA500;
  endfunction

  // zero-wait memory: always ready, data one cycle after accept
  always @(posedge clk or posedge reset)
    if (reset) begin
      pend0 <= 0;
      pend1 <= 0;
    end else begin
      pend0 <= imem_req & imem_ready;
      data0 <= word(imem_addr);
      pend1 <= req1;
      data1 <= word(addr1);
    end

  assign imem_ready = auto ? 1'b1 : man_ready;
  assign imem_rvalid = auto ? pend0 : man_rvalid;
  assign imem_rdata = auto ? data0 : man_rdata;

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic do_reset;
    reset = 1; jump = 0; stall = 0; auto = 1;
    man_ready = 0; man_rvalid = 0; man_rdata = 0;
    tick(1);
    reset = 0;
  endtask

  task automatic test_reset;
    #1 reset = 1;
    #1;
    checks++;
    if ({imem_req, imem_addr, valid_out, pc_out, pcp2_out, ir_out} !== {1'b0, 16'h0, 1'b0, 48'h0}) begin
      errors++; $display("FAIL reset_outputs req=%b addr=%h v=%b pc=%h pcp2=%h ir=%h want all 0", imem_req, imem_addr, valid_out, pc_out, pcp2_out, ir_out);
    end
    checks++;
    if ({req1, addr1, valid1} !== {1'b0, 16'hFFFC, 1'b0}) begin
      errors++; $display("FAIL reset_pc_param req=%b addr=%h v=%b want 0 fffc 0", req1, addr1, valid1);
    end
    tick(1);
    reset = 0;
  endtask

  task automatic test_stream;
    tick(1);
    checks++;
    if ({valid_out, imem_req, imem_addr} !== {1'b0, 1'b1, 16'h0000}) begin
      errors++; $display("FAIL stream_e1 v=%b req=%b addr=%h want 0 1 0000", valid_out, imem_req, imem_addr);
    end
    tick(1);
    checks++;
    if ({valid_out, imem_req} !== 2'b00) begin
      errors++; $display("FAIL stream_e2 v=%b req=%b want 0 0", valid_out, imem_req);
    end
    tick(1);
    checks++;
    if ({valid_out, pc_out, pcp2_out, ir_out, imem_req, imem_addr} !== {1'b1, 16'h0000, 16'h0002, 16'h1111, 1'b1, 16'h0002}) begin
      errors++; $display("FAIL stream_e3 v=%b pc=%h pcp2=%h ir=%h req=%b addr=%h want 1 0000 0002 1111 1 0002", valid_out, pc_out, pcp2_out, ir_out, imem_req, imem_addr);
    end
    tick(1);
    checks++;
    if ({valid_out, pc_out, ir_out} !== {1'b0, 32'h0}) begin
      errors++; $display("FAIL stream_e4_bubble v=%b pc=%h ir=%h want 0 0000 0000", valid_out, pc_out, ir_out);
    end
    tick(1);
    checks++;
    if ({valid_out, pc_out, pcp2_out, ir_out} !== {1'b1, 16'h0002, 16'h0004, 16'h2222}) begin
      errors++; $display("FAIL stream_e5 v=%b pc=%h pcp2=%h ir=%h want 1 0002 0004 2222", valid_out, pc_out, pcp2_out, ir_out);
    end
  endtask

  task automatic test_stall;
    do_reset;
    stall = 1;
    tick(5);
    checks++;
    if ({imem_req, valid_out, pc_out, ir_out} !== {1'b0, 1'b1, 16'h0000, 16'h1111}) begin
      errors++; $display("FAIL stall_full req=%b v=%b pc=%h ir=%h want 0 1 0000 1111", imem_req, valid_out, pc_out, ir_out);
    end
    tick(1);
    checks++;
    if ({imem_req, valid_out, pc_out} !== {1'b0, 1'b1, 16'h0000}) begin
      errors++; $display("FAIL stall_hold req=%b v=%b pc=%h want 0 1 0000", imem_req, valid_out, pc_out);
    end
    stall = 0;
    tick(1);
    checks++;
    if ({imem_req, valid_out, pc_out, pcp2_out, ir_out} !== {1'b0, 1'b1, 16'h0002, 16'h0004, 16'h2222}) begin
      errors++; $display("FAIL stall_pop1 req=%b v=%b pc=%h pcp2=%h ir=%h want 0 1 0002 0004 2222", imem_req, valid_out, pc_out, pcp2_out, ir_out);
    end
    tick(1);
    checks++;
    if ({valid_out, imem_req, imem_addr} !== {1'b0, 1'b1, 16'h0004}) begin
      errors++; $display("FAIL stall_pop2 v=%b req=%b addr=%h want 0 1 0004", valid_out, imem_req, imem_addr);
    end
    tick(2);
    checks++;
    if ({valid_out, pc_out, pcp2_out, ir_out} !== {1'b1, 16'h0004, 16'h0006, 16'hA504}) begin
      errors++; $display("FAIL stall_resume v=%b pc=%h pcp2=%h ir=%h want 1 0004 0006 a504", valid_out, pc_out, pcp2_out, ir_out);
    end
  endtask

  task automatic test_jump_wait;
    do_reset;
    auto = 0; man_ready = 1;
    tick(2);
    checks++;
    if ({imem_req, imem_addr} !== {1'b0, 16'h0002}) begin
      errors++; $display("FAIL jw_in_wait req=%b addr=%h want 0 0002", imem_req, imem_addr);
    end
    jump = 1; new_pc = 16'h0041; man_ready = 0;
    tick(1);
    jump = 0;
    checks++;
    if ({valid_out, imem_req, imem_addr} !== {1'b0, 1'b0, 16'h0040}) begin
      errors++; $display("FAIL jw_drop v=%b req=%b addr=%h want 0 0 0040", valid_out, imem_req, imem_addr);
    end
    tick(2);
    checks++;
    if ({valid_out, imem_req} !== 2'b00) begin
      errors++; $display("FAIL jw_still_drop v=%b req=%b want 0 0", valid_out, imem_req);
    end
    man_rvalid = 1; man_rdata = 16'hBEEF;
    tick(1);
    man_rvalid = 0;
    checks++;
    if ({valid_out, imem_req, imem_addr} !== {1'b0, 1'b1, 16'h0040}) begin
      errors++; $display("FAIL jw_stale v=%b req=%b addr=%h want 0 1 0040", valid_out, imem_req, imem_addr);
    end
    auto = 1;
    tick(2);
    checks++;
    if ({valid_out, pc_out, pcp2_out, ir_out} !== {1'b1, 16'h0040, 16'h0042, 16'hA540}) begin
      errors++; $display("FAIL jw_target v=%b pc=%h pcp2=%h ir=%h want 1 0040 0042 a540", valid_out, pc_out, pcp2_out, ir_out);
    end
  endtask

  task automatic test_jump_accept;
    do_reset;
    stall = 1;
    tick(3);
    checks++;
    if ({valid_out, pc_out, imem_req, imem_addr} !== {1'b1, 16'h0000, 1'b1, 16'h0002}) begin
      errors++; $display("FAIL ja_pre v=%b pc=%h req=%b addr=%h want 1 0000 1 0002", valid_out, pc_out, imem_req, imem_addr);
    end
    jump = 1; new_pc = 16'h0080;
    tick(1);
    jump = 0;
    checks++;
    if ({valid_out, imem_req, imem_addr} !== {1'b0, 1'b0, 16'h0080}) begin
      errors++; $display("FAIL ja_flush v=%b req=%b addr=%h want 0 0 0080", valid_out, imem_req, imem_addr);
    end
    tick(1);
    checks++;
    if ({valid_out, imem_req, imem_addr} !== {1'b0, 1'b1, 16'h0080}) begin
      errors++; $display("FAIL ja_refetch v=%b req=%b addr=%h want 0 1 0080", valid_out, imem_req, imem_addr);
    end
    tick(2);
    checks++;
    if ({valid_out, pc_out, pcp2_out, ir_out} !== {1'b1, 16'h0080, 16'h0082, 16'hA580}) begin
      errors++; $display("FAIL ja_target v=%b pc=%h pcp2=%h ir=%h want 1 0080 0082 a580", valid_out, pc_out, pcp2_out, ir_out);
    end
    stall = 0;
  endtask

  task automatic test_wrap;
    do_reset;
    tick(3);
    checks++;
    if ({valid1, pc1, pcp21, ir1} !== {1'b1, 16'hFFFC, 16'hFFFE, 16'h5AFC}) begin
      errors++; $display("FAIL wrap_fffc v=%b pc=%h pcp2=%h ir=%h want 1 fffc fffe 5afc", valid1, pc1, pcp21, ir1);
    end
    tick(2);
    checks++;
    if ({valid1, pc1, pcp21, ir1} !== {1'b1, 16'hFFFE, 16'h0000, 16'h5AFE}) begin
      errors++; $display("FAIL wrap_fffe v=%b pc=%h pcp2=%h ir=%h want 1 fffe 0000 5afe", valid1, pc1, pcp21, ir1);
    end
    tick(2);
    checks++;
    if ({valid1, pc1, pcp21, ir1} !== {1'b1, 16'h0000, 16'h0002, 16'h1111}) begin
      errors++; $display("FAIL wrap_0000 v=%b pc=%h pcp2=%h ir=%h want 1 0000 0002 1111", valid1, pc1, pcp21, ir1);
    end
  endtask

  task automatic test_reset_wait;
    do_reset;
    auto = 0; man_ready = 1;
    tick(2);
    man_ready = 0;
    checks++;
    if ({imem_req, imem_addr} !== {1'b0, 16'h0002}) begin
      errors++; $display("FAIL rw_in_wait req=%b addr=%h want 0 0002", imem_req, imem_addr);
    end
    reset = 1;
    #1;
    checks++;
    if ({imem_req, imem_addr, valid_out, pc_out, pcp2_out, ir_out} !== {1'b0, 16'h0, 1'b0, 48'h0}) begin
      errors++; $display("FAIL rw_async req=%b addr=%h v=%b pc=%h pcp2=%h ir=%h want all 0", imem_req, imem_addr, valid_out, pc_out, pcp2_out, ir_out);
    end
    tick(1);
    reset = 0; man_rvalid = 1; man_rdata = 16'hDEAD;
    tick(1);
    man_rvalid = 0;
    checks++;
    if ({valid_out, ir_out, imem_req, imem_addr} !== {1'b0, 16'h0000, 1'b1, 16'h0000}) begin
      errors++; $display("FAIL rw_ignored v=%b ir=%h req=%b addr=%h want 0 0000 1 0000", valid_out, ir_out, imem_req, imem_addr);
    end
    tick(1);
    checks++;
    if ({valid_out, imem_req} !== 2'b01) begin
      errors++; $display("FAIL rw_no_push v=%b req=%b want 0 1", valid_out, imem_req);
    end
  endtask

  initial begin
    test_reset;
    test_stream;
    test_stall;
    test_jump_wait;
    test_jump_accept;
    test_wrap;
    test_reset_wait;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
